// File: rtl/i2c_bus_share_arb.sv
// Two-master I2C bus share: filtered bus-state tracking, idle-only grant with
// round-robin tie break, SCL-low timeout revoke, and registered pad drive mux.
module i2c_bus_share_arb #(
    parameter int FILT_LEN    = 3,
    parameter int BUF_CYC     = 64,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic mcu_scl_out,
    input  logic mcu_sda_out,
    input  logic mcu_scl_oe_n,
    input  logic mcu_sda_oe_n,
    input  logic mcu_req,
    output logic mcu_gnt,
    output logic mcu_scl_in,
    output logic mcu_sda_in,
    input  logic fab_req,
    output logic fab_gnt,
    input  logic fab_scl_oe,
    input  logic fab_sda_oe,
    output logic fab_scl_in,
    output logic fab_sda_in,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    output logic scl_pad_oe,
    output logic sda_pad_oe,
    output logic bus_busy,
    output logic timeout_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int BW = $clog2(BUF_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_MCU = 2'd1,
        GNT_FAB = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Index 0 is SCL, index 1 is SDA throughout the input path.
    logic [1:0]         sync1_r;
    logic [1:0]         sync2_r;
    logic [1:0]         filt_r;
    logic [1:0][FW-1:0] fcnt_r;
    logic               sda_f_d_r;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               last_fab_r;
    logic               mcu_rev_r;
    logic               fab_rev_r;
    logic               bus_busy_r;
    logic               timeout_err_r;
    logic [TW-1:0]      tcnt_r;
    logic [BW-1:0]      bcnt_r;
    logic [BW-1:0]      free_cnt_r;
    logic               mcu_gnt_r;
    logic               fab_gnt_r;
    logic               scl_oe_r;
    logic               sda_oe_r;

    logic               scl_f_s;
    logic               sda_f_s;
    logic               start_s;
    logic               stop_s;
    logic               in_gnt_s;
    logic               timeout_s;
    logic               bus_free_s;
    logic               mcu_ok_s;
    logic               fab_ok_s;
    logic               scl_oe_nxt_s;
    logic               sda_oe_nxt_s;
    logic               mcu_scl_drv_s;
    logic               mcu_sda_drv_s;

    assign scl_f_s       = filt_r[0];
    assign sda_f_s       = filt_r[1];
    assign start_s       = scl_f_s & sda_f_d_r & ~sda_f_s;
    assign stop_s        = scl_f_s & ~sda_f_d_r & sda_f_s;
    assign mcu_scl_drv_s = ~mcu_scl_oe_n & ~mcu_scl_out;
    assign mcu_sda_drv_s = ~mcu_sda_oe_n & ~mcu_sda_out;
    assign in_gnt_s      = (state_r == GNT_MCU) || (state_r == GNT_FAB);
    assign timeout_s     = in_gnt_s && !scl_f_s && (tcnt_r == TW'(TIMEOUT_CYC - 1));
    assign bus_free_s    = (free_cnt_r == BW'(BUF_CYC));
    assign mcu_ok_s      = mcu_req & ~mcu_rev_r;
    assign fab_ok_s      = fab_req & ~fab_rev_r;

    // Synchronizer plus per-line glitch filter; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= 2'b11;
            sync2_r   <= 2'b11;
            filt_r    <= 2'b11;
            fcnt_r    <= '0;
            sda_f_d_r <= 1'b1;
        end else begin
            sync1_r   <= {sda_pad_i, scl_pad_i};
            sync2_r   <= sync1_r;
            sda_f_d_r <= filt_r[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= '0;
                end else if (fcnt_r[i] == FW'(FILT_LEN - 1)) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= '0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FW'(1);
                end
            end
        end
    end

    // Next-state logic; ties go to whichever master did not own the bus last.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!bus_busy_r && bus_free_s) begin
                    if (mcu_ok_s && fab_ok_s) begin
                        state_nxt_s = last_fab_r ? GNT_MCU : GNT_FAB;
                    end else if (mcu_ok_s) begin
                        state_nxt_s = GNT_MCU;
                    end else if (fab_ok_s) begin
                        state_nxt_s = GNT_FAB;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT_MCU: begin
                if (timeout_s || (!mcu_req && !bus_busy_r)) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = GNT_MCU;
                end
            end
            GNT_FAB: begin
                if (timeout_s || (!fab_req && !bus_busy_r)) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = GNT_FAB;
                end
            end
            RELEASE: begin
                if (bcnt_r == BW'(BUF_CYC - 1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pad drive follows the owner of the upcoming state so release is immediate.
    always_comb begin
        scl_oe_nxt_s = 1'b0;
        sda_oe_nxt_s = 1'b0;
        case (state_nxt_s)
            GNT_MCU: begin
                scl_oe_nxt_s = mcu_scl_drv_s;
                sda_oe_nxt_s = mcu_sda_drv_s;
            end
            GNT_FAB: begin
                scl_oe_nxt_s = fab_scl_oe;
                sda_oe_nxt_s = fab_sda_oe;
            end
            default: begin
                scl_oe_nxt_s = 1'b0;
                sda_oe_nxt_s = 1'b0;
            end
        endcase
    end

    // Arbitration state, bus tracking and timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            last_fab_r    <= 1'b1;
            mcu_rev_r     <= 1'b0;
            fab_rev_r     <= 1'b0;
            bus_busy_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            tcnt_r        <= '0;
            bcnt_r        <= '0;
            free_cnt_r    <= BW'(BUF_CYC);
        end else begin
            state_r       <= state_nxt_s;
            timeout_err_r <= timeout_s;

            if ((state_r == IDLE) && (state_nxt_s == GNT_FAB)) begin
                last_fab_r <= 1'b1;
            end else if ((state_r == IDLE) && (state_nxt_s == GNT_MCU)) begin
                last_fab_r <= 1'b0;
            end else begin
                last_fab_r <= last_fab_r;
            end

            // A revoked master must drop its request once before it may re-win.
            if (timeout_s && (state_r == GNT_MCU)) begin
                mcu_rev_r <= 1'b1;
            end else if (!mcu_req) begin
                mcu_rev_r <= 1'b0;
            end else begin
                mcu_rev_r <= mcu_rev_r;
            end
            if (timeout_s && (state_r == GNT_FAB)) begin
                fab_rev_r <= 1'b1;
            end else if (!fab_req) begin
                fab_rev_r <= 1'b0;
            end else begin
                fab_rev_r <= fab_rev_r;
            end

            if (timeout_s) begin
                bus_busy_r <= 1'b0;
            end else if (start_s) begin
                bus_busy_r <= 1'b1;
            end else if (stop_s) begin
                bus_busy_r <= 1'b0;
            end else begin
                bus_busy_r <= bus_busy_r;
            end

            if (!in_gnt_s || (state_nxt_s != state_r) || scl_f_s) begin
                tcnt_r <= '0;
            end else begin
                tcnt_r <= tcnt_r + TW'(1);
            end

            if (state_r == RELEASE) begin
                bcnt_r <= bcnt_r + BW'(1);
            end else begin
                bcnt_r <= '0;
            end

            // Bus-free hold also applies after a STOP from a foreign master.
            if (bus_busy_r) begin
                free_cnt_r <= '0;
            end else if (!bus_free_s) begin
                free_cnt_r <= free_cnt_r + BW'(1);
            end else begin
                free_cnt_r <= free_cnt_r;
            end
        end
    end

    // Registered grants and pad enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcu_gnt_r <= 1'b0;
            fab_gnt_r <= 1'b0;
            scl_oe_r  <= 1'b0;
            sda_oe_r  <= 1'b0;
        end else begin
            mcu_gnt_r <= (state_nxt_s == GNT_MCU);
            fab_gnt_r <= (state_nxt_s == GNT_FAB);
            scl_oe_r  <= scl_oe_nxt_s;
            sda_oe_r  <= sda_oe_nxt_s;
        end
    end

    assign mcu_gnt     = mcu_gnt_r;
    assign fab_gnt     = fab_gnt_r;
    assign scl_pad_oe  = scl_oe_r;
    assign sda_pad_oe  = sda_oe_r;
    assign bus_busy    = bus_busy_r;
    assign timeout_err = timeout_err_r;
    assign mcu_scl_in  = scl_f_s;
    assign mcu_sda_in  = sda_f_s;
    assign fab_scl_in  = scl_f_s;
    assign fab_sda_in  = sda_f_s;

endmodule

// File: doc/i2c_bus_share_arb.md
# i2c_bus_share_arb

Shares one open-drain I2C bus (SCL/SDA pads) between two masters: the MCU hard core, which bit-bangs I2C through its high GPIO lines, and a fabric I2C master. Tracks bus state by detecting START/STOP on the filtered pads, grants ownership only on an idle bus, and muxes the owner's pull-low enables onto the pads. Sits between the MCU GPIO wrapper and the top-level pad buffers in the I2C demo.

## Interface
- FILT_LEN, 3: glitch-filter length in clk cycles; a filtered level changes only after this many consecutive equal synced samples
- BUF_CYC, 64: bus-free hold time in cycles after release, before the next grant
- TIMEOUT_CYC, 500000: maximum cycles filtered SCL may stay low while granted
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mcu_scl_out, mcu_sda_out  in  1  MCU GPIO output values (gpio_h0_out, gpio_h1_out)
- mcu_scl_oe_n, mcu_sda_oe_n  in  1  MCU GPIO output enables, active low (gpio_h0_oe_n, gpio_h1_oe_n)
- mcu_req  in  1  MCU bus request (gpio_h2_out)
- mcu_gnt  out  1  MCU grant (to gpio_h3_in)
- mcu_scl_in, mcu_sda_in  out  1  filtered pad levels returned to MCU (gpio_h0_in, gpio_h1_in)
- fab_req  in  1  fabric master request
- fab_gnt  out  1  fabric grant
- fab_scl_oe, fab_sda_oe  in  1  fabric pull-low enables, active high
- fab_scl_in, fab_sda_in  out  1  filtered pad levels returned to fabric master
- scl_pad_i, sda_pad_i  in  1  raw pad levels
- scl_pad_oe, sda_pad_oe  out  1  pad pull-low enables, registered; 1 drives the pad low, 0 releases it
- bus_busy  out  1  high from a detected START to the next STOP or timeout
- timeout_err  out  1  one-cycle pulse on an SCL-low timeout

## Operation
- Input path: 2-flop synchronizer, then FILT_LEN filter, giving scl_f and sda_f. Both masters' *_in outputs carry scl_f/sda_f regardless of grant.
- START: sda_f falls while scl_f is high. This sets bus_busy. STOP: sda_f rises while scl_f is high. This clears bus_busy. Both are detected in every state, including starts by a third-party master.
- The MCU drive request equals !oe_n & !out, per line. The fabric drive request equals the *_oe input.
- Pad outputs: the owner's drive request is registered onto the pads. A non-owner's drive requests are ignored. In IDLE and RELEASE both pads are released.
- FSM states: IDLE, GNT_MCU, GNT_FAB, RELEASE.
  - IDLE -> GNT_x when req_x=1, bus_busy=0, and req_x has been low at least once since x's last revoke.
  - If both requests arrive in the same cycle, the master that was not last owner wins. last_owner resets to FAB, so the MCU wins the first tie.
  - GNT_x -> RELEASE when req_x=0 and bus_busy=0. If req_x drops while busy, the grant is held until STOP.
  - GNT_x -> RELEASE on timeout. This clears bus_busy, pulses timeout_err, and marks x as revoked.
  - RELEASE counts BUF_CYC cycles, then goes to IDLE.
- Timeout counter runs only in GNT states. It increments while scl_f=0 and clears when scl_f=1 or on any state change. The timeout fires when the count reaches TIMEOUT_CYC-1.
- A requester that is not granted is never told to back off. It must wait for its *_gnt.

## Timing
- Reset values: mcu_gnt=0, fab_gnt=0, scl_pad_oe=0, sda_pad_oe=0, bus_busy=0, timeout_err=0, state IDLE, last_owner=FAB, revoke flags clear.
- Filtered outputs on reset are scl_f=1 and sda_f=1, so *_in read 1.
- Reset asserted mid-transfer releases both pads and both grants immediately (asynchronously), with no STOP generated.
- Pad to filtered level: 2 + FILT_LEN cycles. START/STOP to bus_busy: one further cycle.
- req to gnt: gnt is high the cycle after req is sampled in IDLE with bus free.
- Owner drive to pad_oe: 1 cycle.
- Grant drop to RELEASE: the gnt line falls in the same edge the FSM enters RELEASE. The pads are released at that edge.
- Releasing to re-grant: at least BUF_CYC+1 cycles from leaving GNT to the next gnt.
- timeout_err is high for exactly the cycle the FSM is in its first RELEASE cycle.

## Test plan
- MCU-only transfer: mcu_req=1 on an idle bus -> mcu_gnt=1 next cycle. Then drive START, 9 SCL pulses, STOP -> pads follow the MCU with 1-cycle lag, and bus_busy spans START through STOP+1. Then drop req -> RELEASE for 64 cycles, then IDLE.
- Simultaneous requests: mcu_req and fab_req rise together after reset -> MCU granted. After its release and 64 cycles -> fab_gnt=1. Repeat the tie -> MCU granted again (round-robin).
- Hold while busy: fab_req drops between START and STOP -> fab_gnt stays 1 until STOP is detected, then falls. MCU drive requests during this time leave the pads unchanged.
- Timeout: with TIMEOUT_CYC=100, the fabric holds SCL low for 150 cycles -> at count 100 the pads are released, a timeout_err pulse fires, and bus_busy=0. With fab_req held high -> no re-grant until fab_req toggles low.
- Glitch and foreign master: a 2-cycle SDA low pulse with SCL high -> no START. A foreign START on the pads while in IDLE -> a pending mcu_req is not granted until the foreign STOP + 64 cycles.
- Async reset mid-transfer while GNT_FAB is driving SDA low -> sda_pad_oe=0 and fab_gnt=0 without waiting for a clock edge, and all outputs at reset values.
